// File: rtl/alu_op_sequencer_pkg.sv
// alu_op_sequencer_pkg: opcodes, ALU selects, FSM states and decode record for the ALU op sequencer
package alu_op_sequencer_pkg;
  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_MULT  = 8'h06;
  localparam logic [7:0] OP_SLL   = 8'h07;
  localparam logic [7:0] OP_SRL   = 8'h08;
  localparam logic [7:0] OP_SRA   = 8'h09;
  localparam logic [7:0] OP_ROR   = 8'h0A;
  localparam logic [7:0] OP_BEQ   = 8'h0B;
  localparam logic [2:0] SEL_FWD  = 3'b000;
  localparam logic [2:0] SEL_ADD  = 3'b001;
  localparam logic [2:0] SEL_AND  = 3'b010;
  localparam logic [2:0] SEL_OR   = 3'b011;
  localparam logic [2:0] SEL_MULT = 3'b100;
  localparam logic [2:0] SEL_SL   = 3'b101;
  localparam logic [2:0] SEL_SRA  = 3'b110;
  localparam logic [2:0] SEL_ROR  = 3'b111;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_EXEC2, S_DONE} state_t;
  typedef struct packed {
    logic [2:0] alu_select;
    logic       negate_op2;
    logic       two_pass;
    logic       lat_class;
    logic       writes_back;
    logic       is_branch;
    logic       illegal;
  } dec_t;
  function automatic logic [7:0] srl_mask(input logic [7:0] n);
    return n < 8'd8 ? 8'hFF >> n[2:0] : 8'h00;
  endfunction
endpackage

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: request, ALU and write-back/branch signals between decoder, sequencer and ALU
interface alu_op_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_opcode;
  logic [2:0] req_dest;
  logic [7:0] req_data1;
  logic [7:0] req_data2;
  logic [7:0] alu_data1;
  logic [7:0] alu_data2;
  logic [2:0] alu_select;
  logic [7:0] alu_result;
  logic       alu_zero;
  logic       wb_en;
  logic [2:0] wb_addr;
  logic [7:0] wb_data;
  logic       br_valid;
  logic       br_taken;
  logic       illegal;
  logic       busy;
  modport slave (
    input  req_valid, req_opcode, req_dest, req_data1, req_data2, alu_result, alu_zero,
    output req_ready, alu_data1, alu_data2, alu_select, wb_en, wb_addr, wb_data,
           br_valid, br_taken, illegal, busy
  );
  modport master (
    output req_valid, req_opcode, req_dest, req_data1, req_data2, alu_result, alu_zero,
    input  req_ready, alu_data1, alu_data2, alu_select, wb_en, wb_addr, wb_data,
           br_valid, br_taken, illegal, busy
  );
endinterface

// File: rtl/seq_op_decode.sv
// seq_op_decode: maps a sequencer opcode to ALU select and sequencing attributes
module seq_op_decode
  import alu_op_sequencer_pkg::*;
(
  input  logic [7:0] opcode,
  output dec_t       dec
);
  always_comb begin
    dec = '0;
    case (opcode)
      OP_ADD, OP_SUB, OP_BEQ: dec.alu_select = SEL_ADD;
      OP_AND:                 dec.alu_select = SEL_AND;
      OP_OR:                  dec.alu_select = SEL_OR;
      OP_MULT:                dec.alu_select = SEL_MULT;
      OP_SLL:                 dec.alu_select = SEL_SL;
      OP_SRA:                 dec.alu_select = SEL_SRA;
      OP_SRL, OP_ROR:         dec.alu_select = SEL_ROR;
      default:                dec.alu_select = SEL_FWD;
    endcase
    dec.illegal     = opcode > OP_BEQ;
    dec.negate_op2  = opcode == OP_SUB || opcode == OP_BEQ;
    dec.two_pass    = opcode == OP_SRL;
    dec.lat_class   = opcode == OP_MULT;
    dec.is_branch   = opcode == OP_BEQ;
    dec.writes_back = !dec.illegal && !dec.is_branch;
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: multi-cycle ALU op controller with write-back/branch issue; ALU_SEQ_PERF_EN adds op/stall counters
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int LAT_SIMPLE = 1,
  parameter int LAT_MULT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  alu_op_sequencer_if.slave bus
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [15:0] op_count,
  output logic [15:0] stall_count
`endif
);
  state_t     state, state_nxt;
  dec_t       dec;
  logic [7:0] cnt;
  logic [7:0] mask_q;
  logic [2:0] dest_q;
  logic       wb_q, br_q, two_pass_q, zero_q;
  logic       accept;
  seq_op_decode u_decode (.opcode(bus.req_opcode), .dec(dec));
  assign accept = bus.req_valid && state == S_IDLE;
  always_ff @(posedge clk) state <= reset ? S_IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = accept && !dec.illegal ? S_EXEC : S_IDLE;
      S_EXEC:  state_nxt = cnt != 0 ? S_EXEC : two_pass_q ? S_EXEC2 : S_DONE;
      S_EXEC2: state_nxt = cnt != 0 ? S_EXEC2 : S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end
  always_comb begin
    bus.req_ready = state == S_IDLE;
    bus.busy      = state != S_IDLE;
    bus.wb_en     = state == S_DONE && wb_q;
    bus.br_valid  = state == S_DONE && br_q;
    bus.br_taken  = state == S_DONE && br_q && zero_q;
  end
  // SRL pass 1 result is fed straight back as the AND operand for pass 2
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt            <= '0;
      mask_q         <= '0;
      dest_q         <= '0;
      wb_q           <= 1'b0;
      br_q           <= 1'b0;
      two_pass_q     <= 1'b0;
      zero_q         <= 1'b0;
      bus.illegal    <= 1'b0;
      bus.alu_data1  <= '0;
      bus.alu_data2  <= '0;
      bus.alu_select <= '0;
      bus.wb_addr    <= '0;
      bus.wb_data    <= '0;
    end else begin
      bus.illegal <= accept && dec.illegal;
      if (accept && !dec.illegal) begin
        cnt            <= dec.lat_class ? 8'(LAT_MULT - 1) : 8'(LAT_SIMPLE - 1);
        mask_q         <= srl_mask(bus.req_data2);
        dest_q         <= bus.req_dest;
        wb_q           <= dec.writes_back;
        br_q           <= dec.is_branch;
        two_pass_q     <= dec.two_pass;
        bus.alu_data1  <= bus.req_data1;
        bus.alu_data2  <= dec.negate_op2 ? -bus.req_data2 : bus.req_data2;
        bus.alu_select <= dec.alu_select;
      end else if (state == S_EXEC || state == S_EXEC2) begin
        if (cnt != 0) begin
          cnt <= cnt - 8'd1;
        end else if (state == S_EXEC && two_pass_q) begin
          cnt            <= 8'(LAT_SIMPLE - 1);
          bus.alu_data1  <= bus.alu_result;
          bus.alu_data2  <= mask_q;
          bus.alu_select <= SEL_AND;
        end else begin
          zero_q <= bus.alu_zero;
          if (wb_q) begin
            bus.wb_addr <= dest_q;
            bus.wb_data <= bus.alu_result;
          end
        end
      end
    end
  end
`ifdef ALU_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      op_count    <= '0;
      stall_count <= '0;
    end else begin
      if (state == S_DONE && op_count != 16'hFFFF) op_count <= op_count + 16'd1;
      if (bus.req_valid && bus.busy && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
    end
  end
`endif
endmodule
